// File: rtl/inst_fetch_queue_if.sv
// Purpose : handshake/bus bundle between the IFU, the fetch queue and decode.
// Latency : wires only; no state.
// Backpressure: stall_ifu holds the IFU side, out_ready holds the queue head.
//
// Signals:
//   in_valid/in_inst/in_pc/in_pc_plus_4  IFU -> queue instruction
//   stall_ifu                            queue -> IFU, high when full
//   flush                                redirect, discards every entry
//   out_valid/out_inst/out_pc/out_pc_plus_4  queue head -> decode
//   out_ready                            decode consumes the head
//   count                                current occupancy
// modport master: the IFU/decode environment; modport slave: the queue.

`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

interface inst_fetch_queue_if #(
    parameter int IAW   = `INST_ADDR_WIDTH,
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [31:0]      in_inst;
    logic [IAW-1:0]   in_pc;
    logic [IAW-1:0]   in_pc_plus_4;
    logic             stall_ifu;
    logic             flush;
    logic             out_valid;
    logic [31:0]      out_inst;
    logic [IAW-1:0]   out_pc;
    logic [IAW-1:0]   out_pc_plus_4;
    logic             out_ready;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_inst, in_pc, in_pc_plus_4, flush, out_ready,
        input  stall_ifu, out_valid, out_inst, out_pc, out_pc_plus_4, count
    );

    modport slave (
        input  in_valid, in_inst, in_pc, in_pc_plus_4, flush, out_ready,
        output stall_ifu, out_valid, out_inst, out_pc, out_pc_plus_4, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Purpose : decoupling FIFO between the IFU output registers and decode.
// Latency : 1 cycle enqueue-to-head; 0 cycles through the empty-queue bypass when IFQ_BYPASS_EN is defined.
// Backpressure: stall_ifu = full (registered state only); head held until out_ready.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; wins over flush/enqueue/dequeue
//   ifq    inst_fetch_queue_if.slave (IFU input, stall, flush, decode output, count)
// Optional feature macro: IFQ_BYPASS_EN (empty-queue combinational pass-through).

`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module inst_fetch_queue #(
    parameter int DEPTH           = 8,
    parameter int INST_ADDR_WIDTH = `INST_ADDR_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    inst_fetch_queue_if.slave  ifq
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int IAW   = INST_ADDR_WIDTH;

    typedef struct packed {
        logic [31:0]    inst;
        logic [IAW-1:0] pc;
        logic [IAW-1:0] pc_plus_4;
    } entry_t;

    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    entry_t in_entry;
    entry_t head_entry;
    logic   full;
    logic   empty;
    logic   bypass;
    logic   enq;
    logic   deq;

    assign in_entry   = '{inst: ifq.in_inst, pc: ifq.in_pc, pc_plus_4: ifq.in_pc_plus_4};
    assign head_entry = entry_q[rd_ptr_q];
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);

`ifdef IFQ_BYPASS_EN
    // Empty queue with decode ready: hand the instruction straight through
    // without touching storage, pointers or count.
    assign bypass = empty && ifq.in_valid && ifq.out_ready && !ifq.flush;
`else
    assign bypass = 1'b0;
`endif

    // Full blocks enqueue even when the head drains this cycle; the IFU
    // holds its instruction, so it is simply taken one cycle later.
    assign enq = ifq.in_valid && !full && !ifq.flush && !bypass;
    assign deq = !empty && ifq.out_ready && !ifq.flush;

    always_comb begin
        entry_d  = entry_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (enq) begin
            entry_d[wr_ptr_q] = in_entry;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Redirect empties the queue; storage is left as-is since it is
        // unreachable until rewritten.
        if (ifq.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q  <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entry_q  <= entry_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        ifq.out_valid     = !empty;
        ifq.out_inst      = head_entry.inst;
        ifq.out_pc        = head_entry.pc;
        ifq.out_pc_plus_4 = head_entry.pc_plus_4;
        if (bypass) begin
            ifq.out_valid     = 1'b1;
            ifq.out_inst      = ifq.in_inst;
            ifq.out_pc        = ifq.in_pc;
            ifq.out_pc_plus_4 = ifq.in_pc_plus_4;
        end
    end

    assign ifq.stall_ifu = full;
    assign ifq.count     = count_q;

    a_no_enq_when_full : assert property (@(posedge clk) disable iff (reset)
        !(enq && count_q == CNT_W'(DEPTH)));
    a_no_deq_when_empty : assert property (@(posedge clk) disable iff (reset)
        !(deq && count_q == '0));

endmodule
